axi64_to_xge64_arb: RTL and testbench

AXI64_TO_XGE64_ARB -- requirements
Module: axi64_to_xge64_arb

---
 rtl/xge_arb_pkg.sv | 12 +
 rtl/rr_arb2.sv | 9 +
 rtl/axi64_to_xge64_arb.sv | 121 ++++++++++++
 tb/tb_axi64_to_xge64_arb.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xge_arb_pkg.sv
// xge_arb_pkg: shared state encoding, counter width and saturating increment for the XGE arbiter
package xge_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } state_e;
  localparam int CNT_W = 16;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-request round-robin pick; a tie goes to the port that was not granted last
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);
  // Lone requester wins; on a tie the other port from last time wins
  always_comb grant = &req ? ~last_grant : req[1];
endmodule

// File: rtl/axi64_to_xge64_arb.sv
// axi64_to_xge64_arb: round-robin merge of two 64-bit AXI-stream packet sources onto an XGE MAC TX port
module axi64_to_xge64_arb
  import xge_arb_pkg::*;
#(
  parameter int IFG_CYCLES = 1,
  parameter int LABEL      = 0
) (
  input  logic             xgmii_clk,
  input  logic             xgmii_reset_n,
  input  logic [63:0]      s0_axis_tdata,
  input  logic [3:0]       s0_axis_tuser,
  input  logic             s0_axis_tlast,
  input  logic             s0_axis_tvalid,
  output logic             s0_axis_tready,
  input  logic [63:0]      s1_axis_tdata,
  input  logic [3:0]       s1_axis_tuser,
  input  logic             s1_axis_tlast,
  input  logic             s1_axis_tvalid,
  output logic             s1_axis_tready,
  output logic [63:0]      pkt_tx_data,
  output logic [2:0]       pkt_tx_mod,
  output logic             pkt_tx_sop,
  output logic             pkt_tx_eop,
  output logic             pkt_tx_val,
  input  logic             pkt_tx_full,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1,
  output logic [CNT_W-1:0] drop_cnt
);
  localparam logic [3:0] IFG_LAST = 4'(IFG_CYCLES - 1);
  if (LABEL < 0) begin : g_label
  end
  state_e           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic             first_beat_q, first_beat_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] pkt_cnt0_q, pkt_cnt0_d;
  logic [CNT_W-1:0] pkt_cnt1_q, pkt_cnt1_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             arb_grant;
  logic             s_valid, s_last, rdy, hs, done;
  logic [3:0]       s_user;
  rr_arb2 u_rr (
    .req       ({s1_axis_tvalid, s0_axis_tvalid}),
    .last_grant(last_grant_q),
    .grant     (arb_grant)
  );
  // Granted-port datapath; reset gates every handshake output to 0 immediately
  always_comb begin
    s_valid        = grant_q ? s1_axis_tvalid : s0_axis_tvalid;
    s_last         = grant_q ? s1_axis_tlast : s0_axis_tlast;
    s_user         = grant_q ? s1_axis_tuser : s0_axis_tuser;
    pkt_tx_data    = grant_q ? s1_axis_tdata : s0_axis_tdata;
    rdy            = xgmii_reset_n & (state_q == ST_XFER) & ~pkt_tx_full;
    hs             = rdy & s_valid;
    done           = hs & s_last;
    s0_axis_tready = rdy & ~grant_q;
    s1_axis_tready = rdy & grant_q;
    pkt_tx_val     = hs;
    pkt_tx_sop     = hs & first_beat_q;
    pkt_tx_eop     = done;
    pkt_tx_mod     = done ? s_user[2:0] : 3'd0;
    pkt_cnt0       = pkt_cnt0_q;
    pkt_cnt1       = pkt_cnt1_q;
    drop_cnt       = drop_cnt_q;
  end
  // Next-state: grant in IDLE, hold grant through XFER until tlast, then inter-frame gap
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    first_beat_d = first_beat_q;
    gap_cnt_d    = gap_cnt_q;
    pkt_cnt0_d   = (done & ~grant_q) ? sat_inc(pkt_cnt0_q) : pkt_cnt0_q;
    pkt_cnt1_d   = (done & grant_q) ? sat_inc(pkt_cnt1_q) : pkt_cnt1_q;
    drop_cnt_d   = (done & s_user[3]) ? sat_inc(drop_cnt_q) : drop_cnt_q;
    case (state_q)
      ST_IDLE: if (s0_axis_tvalid | s1_axis_tvalid) begin
        state_d      = ST_XFER;
        grant_d      = arb_grant;
        first_beat_d = 1'b1;
      end
      ST_XFER: begin
        first_beat_d = hs ? 1'b0 : first_beat_q;
        if (done) begin
          last_grant_d = grant_q;
          gap_cnt_d    = 4'd0;
          state_d      = (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        gap_cnt_d = (gap_cnt_q == IFG_LAST) ? 4'd0 : gap_cnt_q + 4'd1;
        state_d   = (gap_cnt_q == IFG_LAST) ? ST_IDLE : ST_GAP;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // State and counter registers with synchronous active-low reset
  always_ff @(posedge xgmii_clk) begin
    if (!xgmii_reset_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      first_beat_q <= 1'b0;
      gap_cnt_q    <= 4'd0;
      pkt_cnt0_q   <= '0;
      pkt_cnt1_q   <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      first_beat_q <= first_beat_d;
      gap_cnt_q    <= gap_cnt_d;
      pkt_cnt0_q   <= pkt_cnt0_d;
      pkt_cnt1_q   <= pkt_cnt1_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end
endmodule

// File: tb/tb_axi64_to_xge64_arb.sv
// tb_axi64_to_xge64_arb: table vectors, hand sequences and randomized scoreboard for the XGE arbiter
module tb_axi64_to_xge64_arb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] s0_axis_tdata, s1_axis_tdata;
  logic [3:0]  s0_axis_tuser, s1_axis_tuser;
  logic        s0_axis_tlast, s1_axis_tlast, s0_axis_tvalid, s1_axis_tvalid;
  logic        s0_axis_tready, s1_axis_tready;
  logic [63:0] pkt_tx_data;
  logic [2:0]  pkt_tx_mod;
  logic        pkt_tx_sop, pkt_tx_eop, pkt_tx_val, pkt_tx_full;
  logic [15:0] pkt_cnt0, pkt_cnt1, drop_cnt;

  axi64_to_xge64_arb #(.IFG_CYCLES(1), .LABEL(0)) dut (
    .xgmii_clk(clk), .xgmii_reset_n(rst_n),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tuser(s0_axis_tuser), .s0_axis_tlast(s0_axis_tlast),
    .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tuser(s1_axis_tuser), .s1_axis_tlast(s1_axis_tlast),
    .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready),
    .pkt_tx_data(pkt_tx_data), .pkt_tx_mod(pkt_tx_mod), .pkt_tx_sop(pkt_tx_sop),
    .pkt_tx_eop(pkt_tx_eop), .pkt_tx_val(pkt_tx_val), .pkt_tx_full(pkt_tx_full),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  user;
    logic        last;
  } beat_t;

  typedef struct {
    logic       v, last, full;
    logic [3:0] user;
    logic       e_rdy, e_val, e_sop, e_eop;
    logic [2:0] e_mod;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  beat_t q0[$], q1[$];
  logic  v[2];
  logic  start[2];
  int    owner;
  int    slog[$];
  int    vprob, fprob;
  logic [15:0] m_cnt[2];
  logic [15:0] m_drop;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] sat(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  task automatic model_clear();
    q0.delete(); q1.delete(); slog.delete();
    v[0] = 1'b0; v[1] = 1'b0; start[0] = 1'b1; start[1] = 1'b1; owner = -1;
    m_cnt[0] = '0; m_cnt[1] = '0; m_drop = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0; pkt_tx_full = 1'b0;
    s0_axis_tlast = 1'b0; s1_axis_tlast = 1'b0; s0_axis_tuser = '0; s1_axis_tuser = '0;
    s0_axis_tdata = '0; s1_axis_tdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic push_pkt(input int p, input int len, input logic [3:0] last_user);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {$urandom, $urandom};
      b.last = (i == len - 1);
      b.user = b.last ? last_user : 4'($urandom_range(15));
      if (p == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  task automatic step();
    beat_t b0, b1, b;
    logic  hs0, hs1;
    int    p;
    @(negedge clk);
    if (!v[0] && q0.size() > 0 && $urandom_range(99) < 32'(vprob)) v[0] = 1'b1;
    if (!v[1] && q1.size() > 0 && $urandom_range(99) < 32'(vprob)) v[1] = 1'b1;
    b0 = (q0.size() > 0) ? q0[0] : '{data: {$urandom, $urandom}, user: 4'hF, last: 1'b1};
    b1 = (q1.size() > 0) ? q1[0] : '{data: {$urandom, $urandom}, user: 4'hF, last: 1'b1};
    s0_axis_tvalid = v[0]; s0_axis_tdata = b0.data; s0_axis_tuser = b0.user; s0_axis_tlast = b0.last;
    s1_axis_tvalid = v[1]; s1_axis_tdata = b1.data; s1_axis_tuser = b1.user; s1_axis_tlast = b1.last;
    pkt_tx_full = ($urandom_range(99) < 32'(fprob));
    #1;
    chk("tready_exclusive", 64'(s0_axis_tready & s1_axis_tready), 64'd0);
    if (pkt_tx_full) chk("tready_when_full", 64'(s0_axis_tready | s1_axis_tready), 64'd0);
    hs0 = v[0] & s0_axis_tready;
    hs1 = v[1] & s1_axis_tready;
    chk("tx_val", 64'(pkt_tx_val), 64'(hs0 | hs1));
    if (hs0 | hs1) begin
      p = hs1 ? 1 : 0;
      b = hs1 ? b1 : b0;
      chk("tx_data", pkt_tx_data, b.data);
      chk("tx_sop", 64'(pkt_tx_sop), 64'(start[p]));
      chk("tx_eop", 64'(pkt_tx_eop), 64'(b.last));
      chk("tx_mod", 64'(pkt_tx_mod), b.last ? 64'(b.user[2:0]) : 64'd0);
      if (owner >= 0) chk("no_interleave_port", 64'(p), 64'(owner));
      if (start[p]) begin
        owner = p;
        slog.push_back(p);
      end
      start[p] = b.last;
      if (b.last) begin
        owner = -1;
        m_cnt[p] = sat(m_cnt[p]);
        if (b.user[3]) m_drop = sat(m_drop);
      end
      if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      v[p] = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < 4000) begin
      step();
      n++;
    end
    chk("drain_q0_left", 64'(q0.size()), 64'd0);
    chk("drain_q1_left", 64'(q1.size()), 64'd0);
    repeat (4) step();
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, "_pkt_cnt0"}, 64'(pkt_cnt0), 64'(m_cnt[0]));
    chk({tag, "_pkt_cnt1"}, 64'(pkt_cnt1), 64'(m_cnt[1]));
    chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(m_drop));
  endtask

  function automatic vec_t mkv(input logic vv, input logic l, input logic [3:0] u, input logic f,
                               input logic r, input logic vl, input logic so, input logic eo,
                               input logic [2:0] m);
    return '{v: vv, last: l, full: f, user: u, e_rdy: r, e_val: vl, e_sop: so, e_eop: eo, e_mod: m};
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[11];
    tbl[0]  = mkv(1, 0, 4'h0, 0,  0, 0, 0, 0, 3'd0);
    tbl[1]  = mkv(1, 0, 4'h0, 0,  1, 1, 1, 0, 3'd0);
    tbl[2]  = mkv(1, 0, 4'h0, 1,  0, 0, 0, 0, 3'd0);
    tbl[3]  = mkv(1, 0, 4'h0, 0,  1, 1, 0, 0, 3'd0);
    tbl[4]  = mkv(0, 0, 4'h0, 0,  1, 0, 0, 0, 3'd0);
    tbl[5]  = mkv(1, 0, 4'h8, 0,  1, 1, 0, 0, 3'd0);
    tbl[6]  = mkv(1, 1, 4'h3, 0,  1, 1, 0, 1, 3'd3);
    tbl[7]  = mkv(1, 1, 4'hD, 0,  0, 0, 0, 0, 3'd0);
    tbl[8]  = mkv(1, 1, 4'hD, 0,  0, 0, 0, 0, 3'd0);
    tbl[9]  = mkv(1, 1, 4'hD, 0,  1, 1, 1, 1, 3'd5);
    tbl[10] = mkv(0, 0, 4'h0, 0,  0, 0, 0, 0, 3'd0);
    vprob = 100; fprob = 0;
    do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("in_reset_val", 64'(pkt_tx_val | pkt_tx_sop | pkt_tx_eop), 64'd0);
    chk("in_reset_tready", 64'(s0_axis_tready | s1_axis_tready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_cnts("reset");

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      s0_axis_tvalid = tbl[i].v; s0_axis_tlast = tbl[i].last; s0_axis_tuser = tbl[i].user;
      s0_axis_tdata = 64'hA000 + 64'(i); pkt_tx_full = tbl[i].full; s1_axis_tvalid = 1'b0;
      #1;
      chk($sformatf("vec%0d_tready0", i), 64'(s0_axis_tready), 64'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_tready1", i), 64'(s1_axis_tready), 64'd0);
      chk($sformatf("vec%0d_val", i), 64'(pkt_tx_val), 64'(tbl[i].e_val));
      chk($sformatf("vec%0d_sop", i), 64'(pkt_tx_sop), 64'(tbl[i].e_sop));
      chk($sformatf("vec%0d_eop", i), 64'(pkt_tx_eop), 64'(tbl[i].e_eop));
      chk($sformatf("vec%0d_mod", i), 64'(pkt_tx_mod), 64'(tbl[i].e_mod));
      if (tbl[i].e_val) chk($sformatf("vec%0d_data", i), pkt_tx_data, 64'hA000 + 64'(i));
    end
    chk("vec_pkt_cnt0", 64'(pkt_cnt0), 64'd2);
    chk("vec_pkt_cnt1", 64'(pkt_cnt1), 64'd0);
    chk("vec_drop_cnt", 64'(drop_cnt), 64'd1);

    @(negedge clk);
    s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b1; s1_axis_tlast = 1'b0; s1_axis_tuser = 4'h0;
    s1_axis_tdata = 64'hB1;
    #1;
    chk("rst_seq_idle_tready1", 64'(s1_axis_tready), 64'd0);
    @(negedge clk);
    #1;
    chk("rst_seq_s1_sop", 64'({s1_axis_tready, pkt_tx_val, pkt_tx_sop}), 64'b111);
    @(negedge clk);
    rst_n = 1'b0; s1_axis_tdata = 64'hB2;
    #1;
    chk("rst_seq_outputs_low", 64'({s0_axis_tready, s1_axis_tready, pkt_tx_val, pkt_tx_sop, pkt_tx_eop}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    s0_axis_tvalid = 1'b1; s0_axis_tlast = 1'b1; s0_axis_tuser = 4'h0; s0_axis_tdata = 64'hC0;
    s1_axis_tlast = 1'b1;
    #1;
    chk("rst_seq_cnts_zero", 64'({pkt_cnt0, pkt_cnt1, drop_cnt}), 64'd0);
    chk("rst_seq_after_tready", 64'({s0_axis_tready, s1_axis_tready, pkt_tx_val}), 64'd0);
    @(negedge clk);
    #1;
    chk("rst_seq_tie_to_s0", 64'({s0_axis_tready, s1_axis_tready}), 64'b10);
    chk("rst_seq_tie_sop_eop", 64'({pkt_tx_sop, pkt_tx_eop}), 64'b11);
    chk("rst_seq_tie_data", pkt_tx_data, 64'hC0);

    do_reset();
    vprob = 100; fprob = 0;
    for (int k = 0; k < 4; k++) begin
      push_pkt(0, 2, 4'h0);
      push_pkt(1, 2, 4'h0);
    end
    drain();
    chk("contend_pkts", 64'(slog.size()), 64'd8);
    foreach (slog[k]) chk($sformatf("contend_grant%0d", k), 64'(slog[k]), 64'(k % 2));
    chk_cnts("contend");

    vprob = 60; fprob = 25;
    slog.delete();
    for (int k = 0; k < 30; k++) begin
      push_pkt(0, $urandom_range(1, 5), 4'($urandom_range(15)));
      push_pkt(1, $urandom_range(1, 5), 4'($urandom_range(15)));
    end
    drain();
    chk_cnts("random");

    @(negedge clk);
    force dut.pkt_cnt0_q = 16'hFFFD;
    @(posedge clk);
    #1;
    release dut.pkt_cnt0_q;
    m_cnt[0] = 16'hFFFD;
    vprob = 100; fprob = 0;
    for (int k = 0; k < 3; k++) push_pkt(0, 1, 4'h0);
    drain();
    chk("sat_pkt_cnt0", 64'(pkt_cnt0), 64'hFFFF);
    chk_cnts("sat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
